// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset PC, canonical nop and the
// {pc, instr} record that travels from instruction fetch into IF/ID.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with wrapping read/write pointers.
// DEPTH must be a power of two so the pointers wrap without compare logic.
// clear empties the FIFO and overrides any push or pop in the same cycle.
// Push while full is accepted only together with a pop (occupancy unchanged).
module sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  T                             wdata,
    input  logic                         pop,
    input  logic                         clear,
    output T                             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !clear && !empty;
    assign do_push = push && !clear && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy bookkeeping; clear behaves like a local reset.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      cnt <= cnt + CW'(1);
            else if (!do_push && do_pop) cnt <= cnt - CW'(1);
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ifetch_prefetch_buffer.sv
// Instruction-fetch prefetch buffer. Issues sequential word fetches to a
// handshaked instruction memory, queues the returned words with their PCs
// and hands them to IF/ID one per cycle. A redirect from ID/EX flushes the
// queue and marks every fetch still in flight to be dropped on return.
//
// Handshakes: a memory fetch is issued when mem_req && mem_gnt in the same
// cycle; each grant returns exactly one mem_rvalid, in order, at least one
// cycle later. Towards IF/ID an entry transfers when fetch_valid &&
// fetch_ready; fetch_valid does not depend on fetch_ready.
module ifetch_prefetch_buffer #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] fetch_instr,
    input  logic            fetch_ready
);

    import cpu_pkg::*;

    localparam int CW  = $clog2(DEPTH+1);
    localparam int CWP = CW + 1;
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

    logic [CW-1:0]   occupancy;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [CWP-1:0]  pending;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target_pc;
    logic            issue;
    logic            resp;
    logic            push;
    logic            pop;
    logic            q_empty;
    logic            q_full;
    logic            unused_pc_bits;
    fetch_entry_t    head;
    fetch_entry_t    wentry;

    // The low two bits of the redirect target are ignored: fetch is word-aligned.
    assign target_pc      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Queued entries plus outstanding fetches never exceed DEPTH, so every
    // returning word is guaranteed a slot without a full check at push time.
    assign pending = {1'b0, occupancy} + {1'b0, inflight};
    assign mem_req  = !rst && !redirect && (pending < CWP'(DEPTH));
    assign mem_addr = next_pc;
    assign issue    = mem_req && mem_gnt;

    // A stray rvalid with nothing outstanding is ignored (and flagged below).
    assign resp = mem_rvalid && (inflight != '0);
    assign push = resp && (drop_cnt == '0) && !redirect;

    assign fetch_valid = !q_empty && !redirect;
    assign pop         = fetch_valid && fetch_ready;
    assign fetch_pc    = q_empty ? RESET_PC  : head.pc;
    assign fetch_instr = q_empty ? NOP_INSTR : head.instr;

    assign wentry = {resp_pc, mem_rdata};

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .clear (redirect),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty),
        .count (occupancy)
    );

    // Outstanding-fetch count: +1 per grant, -1 per returned word.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, resp})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Drop count and PC registers; a redirect re-arms the drop count from
    // whatever is still outstanding once this cycle's return is accounted for.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            next_pc  <= RESET_PC_ALIGNED;
            resp_pc  <= RESET_PC_ALIGNED;
        end else if (redirect) begin
            drop_cnt <= resp ? (inflight - CW'(1)) : inflight;
            next_pc  <= target_pc;
            resp_pc  <= target_pc;
        end else begin
            if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
            if (issue) next_pc <= next_pc + XLEN'(4);
            if (push)  resp_pc <= resp_pc + XLEN'(4);
        end
    end

    // Protocol sanity: returns must match a fetch, and the issue cap must hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_rvalid && (inflight == '0)))
                else $error("ifetch: rvalid with no fetch outstanding");
            assert (!(push && q_full && !pop))
                else $error("ifetch: push into full queue");
        end
    end

endmodule
